// File: rtl/m68k_bus_cycle_sequencer_pkg.sv
// Shared types and constants for the 68000-style bus cycle sequencer.
package m68k_bus_cycle_sequencer_pkg;

   // One state per half MC clock of a bus cycle, plus idle and the pre-S1 wait.
   typedef enum logic [3:0] {
      StIdle,
      StWaitF,
      StS1,
      StS2,
      StS3,
      StS4,
      StS5,
      StS6,
      StS7
   } state_e;

   // Byte enables are {UDS, LDS}, active-high.
   localparam logic [1:0] BE_WORD  = 2'b11;
   localparam logic [1:0] BE_UPPER = 2'b10;
   localparam logic [1:0] BE_LOWER = 2'b01;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

   // Active-low {UDS_N, LDS_N} for a byte-enable pair; 2'b00 leaves both high.
   function automatic logic [1:0] be_to_strobe_n(logic [1:0] be);
      if (be == BE_WORD) begin
         return 2'b00;
      end
      return {~|(be & BE_UPPER), ~|(be & BE_LOWER)};
   endfunction

endpackage

// File: rtl/m68k_dtack_watchdog.sv
// Counts MC falling edges spent in S4 without DTACK; flags expiry on the last allowed edge.
module m68k_dtack_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 11
) (
   input  logic SYSCLK,
   input  logic RESET,
   input  logic clear,
   input  logic tick,
   input  logic dtack_seen,
   output logic expired
);

   // TO_W must hold TIMEOUT_CYCLES-1; the counter stops there instead of wrapping.
   localparam logic [TO_W-1:0] TMax = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] timer_q, timer_d;

   // Next timer value: clear wins, then saturating increment on a DTACK-less tick.
   always_comb begin
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (tick && !dtack_seen && (timer_q != TMax)) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Timer register, same edge as the strobe producer.
   always_ff @(negedge SYSCLK) begin
      if (RESET) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign expired = (timer_q == TMax);

endmodule

// File: rtl/m68k_bus_cycle_sequencer.sv
// Runs one 68000-style read or write bus cycle per accepted request, paced by MC clock strobes.
module m68k_bus_cycle_sequencer
   import m68k_bus_cycle_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned TO_W           = 11
) (
   input  logic        SYSCLK,
   input  logic        RESET,
   input  logic        MCCLK_FALLING,
   input  logic        MCCLK_RISING,
   input  logic        DTACK_LATCH,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [22:0] REQ_ADDR,
   input  logic        REQ_RW,
   input  logic [1:0]  REQ_BE,
   input  logic [15:0] REQ_WDATA,
   output logic        RESP_VALID,
   output logic [15:0] RESP_RDATA,
   output logic        RESP_ERR,
   output logic [22:0] BUS_A,
   input  logic [15:0] BUS_D_IN,
   output logic [15:0] BUS_D_OUT,
   output logic        BUS_D_OE,
   output logic        BUS_AS_N,
   output logic        BUS_UDS_N,
   output logic        BUS_LDS_N,
   output logic        BUS_RW
);

   state_e      state_q, state_d;
   logic [22:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        dtack_seen_q, dtack_seen_d;
   logic        ready_q, ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [15:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [22:0] bus_a_q, bus_a_d;
   logic [15:0] d_out_q, d_out_d;
   logic        d_oe_q, d_oe_d;
   logic        as_n_q, as_n_d;
   logic        uds_n_q, uds_n_d;
   logic        lds_n_q, lds_n_d;
   logic        bus_rw_q, bus_rw_d;

   logic        fall, rise, dtack_now, expired, in_dtack_window;

   // Both strobes at once is illegal; treating it as neither makes the state hold.
   assign fall      = MCCLK_FALLING & ~MCCLK_RISING;
   assign rise      = MCCLK_RISING & ~MCCLK_FALLING;
   // A DTACK pulse coinciding with the S4 falling edge still terminates the wait.
   assign dtack_now = dtack_seen_q | DTACK_LATCH;

   assign in_dtack_window = (state_q == StS1) || (state_q == StS2) ||
                            (state_q == StS3) || (state_q == StS4);

   m68k_dtack_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .SYSCLK     (SYSCLK),
      .RESET      (RESET),
      .clear      (state_q == StIdle),
      .tick       ((state_q == StS4) && fall),
      .dtack_seen (dtack_now),
      .expired    (expired)
   );

   // Next-state and pin/response updates; each state acts only on its own strobe.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rw_d         = rw_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      dtack_seen_d = dtack_seen_q;
      ready_d      = ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      bus_a_d      = bus_a_q;
      d_out_d      = d_out_q;
      d_oe_d       = d_oe_q;
      as_n_d       = as_n_q;
      uds_n_d      = uds_n_q;
      lds_n_d      = lds_n_q;
      bus_rw_d     = bus_rw_q;

      unique case (state_q)
         StIdle: begin
            if (REQ_VALID && ready_q) begin
               addr_d  = REQ_ADDR;
               rw_d    = REQ_RW;
               be_d    = REQ_BE;
               wdata_d = REQ_WDATA;
               err_d   = 1'b0;
               ready_d = 1'b0;
               state_d = StWaitF;
            end
         end
         StWaitF: begin
            if (fall) begin
               bus_a_d  = addr_q;
               bus_rw_d = rw_q;
               state_d  = StS1;
            end
         end
         StS1: begin
            if (rise) begin
               as_n_d = 1'b0;
               if (rw_q) begin
                  {uds_n_d, lds_n_d} = be_to_strobe_n(be_q);
               end
               state_d = StS2;
            end
         end
         StS2: begin
            if (fall) begin
               if (!rw_q) begin
                  d_out_d = wdata_q;
                  d_oe_d  = 1'b1;
               end
               state_d = StS3;
            end
         end
         StS3: begin
            if (rise) begin
               if (!rw_q) begin
                  {uds_n_d, lds_n_d} = be_to_strobe_n(be_q);
               end
               state_d = StS4;
            end
         end
         StS4: begin
            if (fall) begin
               if (dtack_now) begin
                  state_d = StS5;
               end else if (expired) begin
                  err_d   = 1'b1;
                  state_d = StS5;
               end
            end
         end
         StS5: begin
            if (rise) begin
               state_d = StS6;
            end
         end
         StS6: begin
            if (fall) begin
               if (rw_q) begin
                  resp_rdata_d = BUS_D_IN;
               end
               as_n_d  = 1'b1;
               uds_n_d = 1'b1;
               lds_n_d = 1'b1;
               state_d = StS7;
            end
         end
         StS7: begin
            if (rise) begin
               d_oe_d       = 1'b0;
               bus_rw_d     = 1'b1;
               resp_valid_d = 1'b1;
               resp_err_d   = err_q;
               ready_d      = 1'b1;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StIdle) begin
         dtack_seen_d = 1'b0;
      end else if (DTACK_LATCH && in_dtack_window) begin
         dtack_seen_d = 1'b1;
      end
   end

   // State and output registers; reset releases the bus on the very next SYSCLK.
   always_ff @(negedge SYSCLK) begin
      if (RESET) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         rw_q         <= 1'b1;
         be_q         <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         dtack_seen_q <= 1'b0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         bus_a_q      <= '0;
         d_out_q      <= '0;
         d_oe_q       <= 1'b0;
         as_n_q       <= 1'b1;
         uds_n_q      <= 1'b1;
         lds_n_q      <= 1'b1;
         bus_rw_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rw_q         <= rw_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         dtack_seen_q <= dtack_seen_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         bus_a_q      <= bus_a_d;
         d_out_q      <= d_out_d;
         d_oe_q       <= d_oe_d;
         as_n_q       <= as_n_d;
         uds_n_q      <= uds_n_d;
         lds_n_q      <= lds_n_d;
         bus_rw_q     <= bus_rw_d;
      end
   end

   assign REQ_READY  = ready_q;
   assign RESP_VALID = resp_valid_q;
   assign RESP_RDATA = resp_rdata_q;
   assign RESP_ERR   = resp_err_q;
   assign BUS_A      = bus_a_q;
   assign BUS_D_OUT  = d_out_q;
   assign BUS_D_OE   = d_oe_q;
   assign BUS_AS_N   = as_n_q;
   assign BUS_UDS_N  = uds_n_q;
   assign BUS_LDS_N  = lds_n_q;
   assign BUS_RW     = bus_rw_q;

endmodule

// File: tb/tb_m68k_bus_cycle_sequencer.sv
// Scoreboard bench: MC strobes free-run (falling every 4 SYSCLKs, rising 2 later).
module tb_m68k_bus_cycle_sequencer;

   localparam int T = 8;

   logic        SYSCLK, RESET, MCCLK_FALLING, MCCLK_RISING, DTACK_LATCH;
   logic        REQ_VALID, REQ_READY, REQ_RW;
   logic [22:0] REQ_ADDR, BUS_A;
   logic [1:0]  REQ_BE;
   logic [15:0] REQ_WDATA, RESP_RDATA, BUS_D_IN, BUS_D_OUT;
   logic        RESP_VALID, RESP_ERR, BUS_D_OE, BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_RW;

   m68k_bus_cycle_sequencer #(
      .TIMEOUT_CYCLES (T),
      .TO_W           (4)
   ) dut (
      .SYSCLK        (SYSCLK),
      .RESET         (RESET),
      .MCCLK_FALLING (MCCLK_FALLING),
      .MCCLK_RISING  (MCCLK_RISING),
      .DTACK_LATCH   (DTACK_LATCH),
      .REQ_VALID     (REQ_VALID),
      .REQ_READY     (REQ_READY),
      .REQ_ADDR      (REQ_ADDR),
      .REQ_RW        (REQ_RW),
      .REQ_BE        (REQ_BE),
      .REQ_WDATA     (REQ_WDATA),
      .RESP_VALID    (RESP_VALID),
      .RESP_RDATA    (RESP_RDATA),
      .RESP_ERR      (RESP_ERR),
      .BUS_A         (BUS_A),
      .BUS_D_IN      (BUS_D_IN),
      .BUS_D_OUT     (BUS_D_OUT),
      .BUS_D_OE      (BUS_D_OE),
      .BUS_AS_N      (BUS_AS_N),
      .BUS_UDS_N     (BUS_UDS_N),
      .BUS_LDS_N     (BUS_LDS_N),
      .BUS_RW        (BUS_RW)
   );

   typedef struct {
      logic [22:0] addr;
      logic        rw;
      logic [1:0]  be;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          dtack_off;        // DTACK negedge relative to first falling edge, -1 = none
      logic        dtack_on_accept;  // extra DTACK pulse on the accept edge (state IDLE)
   } req_t;

   typedef struct {
      logic        rw;
      logic [15:0] rdata;
      logic        err;
      int          resp_n;
   } exp_t;

   req_t req_q[$];
   exp_t exp_q[$];
   int   acc_log[$];
   int   resp_log[$];

   int   vectors = 0;
   int   miscompares = 0;
   int   ncount = 0;
   int   cur_f1 = -1000;
   int   dtack_at = -1;
   logic rst_next = 1'b1;

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   function automatic req_t mk_req(logic [22:0] addr, logic rw, logic [1:0] be,
                                   logic [15:0] wdata, logic [15:0] rdata, int off,
                                   logic doa);
      req_t r;
      r.addr = addr; r.rw = rw; r.be = be; r.wdata = wdata; r.rdata = rdata;
      r.dtack_off = off; r.dtack_on_accept = doa;
      return r;
   endfunction

   // Reference timing: S4 falling edges sit at f1+8+4k; DTACK counts only from S1 onward.
   function automatic exp_t model(req_t r, int f1);
      exp_t e;
      int   d;
      logic found;
      d = (r.dtack_off >= 0) ? f1 + r.dtack_off : -1;
      found = 1'b0;
      e.err = 1'b1;
      e.resp_n = f1 + 14 + 4 * (T - 1);
      if (d >= f1 + 1) begin
         for (int k = 0; k < T; k++) begin
            if (!found && (f1 + 8 + 4 * k >= d)) begin
               found = 1'b1;
               e.err = 1'b0;
               e.resp_n = f1 + 14 + 4 * k;
            end
         end
      end
      e.rw = r.rw;
      e.rdata = r.rdata;
      return e;
   endfunction

   function automatic logic busy();
      return (req_q.size() != 0) || (exp_q.size() != 0);
   endfunction

   task automatic drive_req();
      if (req_q.size() != 0) begin
         REQ_VALID = 1'b1;
         REQ_ADDR  = req_q[0].addr;
         REQ_RW    = req_q[0].rw;
         REQ_BE    = req_q[0].be;
         REQ_WDATA = req_q[0].wdata;
      end else begin
         REQ_VALID = 1'b0;
      end
   endtask

   // Advance one SYSCLK: set inputs for the next negedge, then sample 2ns after it.
   task automatic cyc();
      int   n1, f1;
      logic acc, dt;
      req_t r;
      exp_t e;
      n1 = ncount + 1;
      acc = (REQ_VALID === 1'b1) && (REQ_READY === 1'b1) && !rst_next && (req_q.size() != 0);
      dt = (n1 == dtack_at);
      if (acc) begin
         r = req_q.pop_front();
         f1 = (n1 / 4 + 1) * 4;
         exp_q.push_back(model(r, f1));
         acc_log.push_back(n1);
         cur_f1 = f1;
         dtack_at = (r.dtack_off >= 0) ? f1 + r.dtack_off : -1;
         if (r.dtack_on_accept) dt = 1'b1;
         BUS_D_IN = r.rdata;
      end
      RESET = rst_next;
      MCCLK_FALLING = (n1 % 4 == 0);
      MCCLK_RISING = (n1 % 4 == 2);
      DTACK_LATCH = dt;
      @(negedge SYSCLK);
      ncount = n1;
      #2;
      drive_req();
      if (RESP_VALID === 1'b1) begin
         resp_log.push_back(ncount);
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL resp_unexpected: RESP_VALID at sysclk %0d, none outstanding", ncount);
         end else begin
            e = exp_q.pop_front();
            if (ncount != e.resp_n) begin
               miscompares++;
               $display("FAIL resp_time: got sysclk %0d, expected %0d", ncount, e.resp_n);
            end
            vectors++;
            if (RESP_ERR !== e.err) begin
               miscompares++;
               $display("FAIL resp_err: got %b, expected %b", RESP_ERR, e.err);
            end
            vectors++;
            if (REQ_READY !== 1'b1) begin
               miscompares++;
               $display("FAIL ready_with_resp: got %b, expected 1", REQ_READY);
            end
            if (e.rw) begin
               vectors++;
               if (RESP_RDATA !== e.rdata) begin
                  miscompares++;
                  $display("FAIL resp_rdata: got %h, expected %h", RESP_RDATA, e.rdata);
               end
            end
         end
      end
   endtask

   task automatic bound_check(string name);
      if (busy()) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_bound: cycle budget expired with work outstanding", name);
         req_q.delete();
         exp_q.delete();
         drive_req();
      end
   endtask

   task automatic start_test();
      cur_f1 = -1000;
      acc_log.delete();
      resp_log.delete();
   endtask

   task automatic test_reset();
      rst_next = 1'b1;
      repeat (3) cyc();
      vectors++;
      if ({REQ_READY, RESP_VALID, RESP_ERR, BUS_D_OE, BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_RW}
          !== 8'b1000_1111) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b, expected 10001111", {REQ_READY, RESP_VALID,
                  RESP_ERR, BUS_D_OE, BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_RW});
      end
      vectors++;
      if ({BUS_A, BUS_D_OUT, RESP_RDATA} !== 55'h0) begin
         miscompares++;
         $display("FAIL reset_data: A=%h DOUT=%h RDATA=%h, expected all zero",
                  BUS_A, BUS_D_OUT, RESP_RDATA);
      end
      rst_next = 1'b0;
      cyc();
   endtask

   task automatic test_word_read();
      int rel;
      start_test();
      req_q.push_back(mk_req(23'h123456, 1'b1, 2'b11, 16'h0, 16'hBEEF, 5, 1'b0));
      drive_req();
      for (int g = 0; g < 200 && busy(); g++) begin
         cyc();
         rel = ncount - cur_f1;
         if (rel == 0) begin
            vectors++;
            if (BUS_A !== 23'h123456 || BUS_RW !== 1'b1 || REQ_READY !== 1'b0) begin
               miscompares++;
               $display("FAIL rd_addr: A=%h RW=%b READY=%b, expected 123456 1 0",
                        BUS_A, BUS_RW, REQ_READY);
            end
         end
         if (rel == 1 || rel == 12) begin
            vectors++;
            if (BUS_AS_N !== 1'b1) begin
               miscompares++;
               $display("FAIL rd_as_high: rel %0d got %b, expected 1", rel, BUS_AS_N);
            end
         end
         if (rel == 2 || rel == 11) begin
            vectors++;
            if ({BUS_AS_N, BUS_UDS_N, BUS_LDS_N} !== 3'b000) begin
               miscompares++;
               $display("FAIL rd_strobes: rel %0d got %b, expected 000",
                        rel, {BUS_AS_N, BUS_UDS_N, BUS_LDS_N});
            end
         end
      end
      bound_check("word_read");
   endtask

   task automatic test_byte_write();
      int rel;
      start_test();
      req_q.push_back(mk_req(23'h000100, 1'b0, 2'b01, 16'h00A5, 16'h0, 5, 1'b0));
      drive_req();
      for (int g = 0; g < 200 && busy(); g++) begin
         cyc();
         rel = ncount - cur_f1;
         if (rel >= 0 && rel <= 14) begin
            vectors++;
            if (BUS_UDS_N !== 1'b1 || BUS_LDS_N !== !(rel >= 6 && rel <= 11)) begin
               miscompares++;
               $display("FAIL wr_strobes: rel %0d UDS_N=%b LDS_N=%b", rel, BUS_UDS_N, BUS_LDS_N);
            end
            vectors++;
            if (BUS_D_OE !== (rel >= 4 && rel <= 13)) begin
               miscompares++;
               $display("FAIL wr_oe: rel %0d got %b", rel, BUS_D_OE);
            end
         end
         if (rel == 4) begin
            vectors++;
            if (BUS_D_OUT !== 16'h00A5 || BUS_RW !== 1'b0) begin
               miscompares++;
               $display("FAIL wr_data: DOUT=%h RW=%b, expected 00a5 0", BUS_D_OUT, BUS_RW);
            end
         end
      end
      bound_check("byte_write");
   endtask

   task automatic test_wait_states();
      start_test();
      req_q.push_back(mk_req(23'h0ABCDE, 1'b1, 2'b11, 16'h0, 16'h0F0F, 17, 1'b0));
      drive_req();
      for (int g = 0; g < 200 && busy(); g++) cyc();
      bound_check("wait_states");
      vectors++;
      if (resp_log.size() != 1 || (resp_log.size() == 1 && resp_log[0] - cur_f1 != 26)) begin
         miscompares++;
         $display("FAIL wait3_latency: %0d responses, expected 1 at first-fall+26",
                  resp_log.size());
      end
   endtask

   task automatic test_timeout();
      int rel;
      start_test();
      req_q.push_back(mk_req(23'h7FFFFF, 1'b1, 2'b11, 16'h0, 16'h1111, -1, 1'b0));
      req_q.push_back(mk_req(23'h000200, 1'b0, 2'b10, 16'h5A5A, 16'h0, 5, 1'b0));
      drive_req();
      for (int g = 0; g < 300 && busy(); g++) begin
         cyc();
         rel = ncount - cur_f1;
         if (acc_log.size() == 2 && rel == 6) begin
            vectors++;
            if ({BUS_UDS_N, BUS_LDS_N} !== 2'b01) begin
               miscompares++;
               $display("FAIL after_to_strobes: got %b, expected 01", {BUS_UDS_N, BUS_LDS_N});
            end
         end
      end
      bound_check("timeout");
   endtask

   task automatic test_reset_mid();
      int rel;
      start_test();
      req_q.push_back(mk_req(23'h055555, 1'b1, 2'b11, 16'h0, 16'h2222, -1, 1'b0));
      drive_req();
      rel = -1;
      for (int g = 0; g < 100 && rel != 9; g++) begin
         cyc();
         rel = ncount - cur_f1;
      end
      vectors++;
      if (rel != 9 || BUS_AS_N !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_setup: rel %0d AS_N=%b, expected S4 with AS_N=0", rel, BUS_AS_N);
      end
      rst_next = 1'b1;
      cyc();
      rst_next = 1'b0;
      exp_q.delete();
      dtack_at = -1;
      vectors++;
      if ({BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_D_OE, REQ_READY, RESP_VALID, BUS_A}
          !== {6'b111010, 23'h0}) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: AS/UDS/LDS/OE/READY/VALID=%b A=%h",
                  {BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_D_OE, REQ_READY, RESP_VALID}, BUS_A);
      end
      repeat (60) cyc();
      vectors++;
      if (resp_log.size() != 0) begin
         miscompares++;
         $display("FAIL rst_mid_noresp: got %0d responses, expected 0", resp_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int rel;
      start_test();
      req_q.push_back(mk_req(23'h011111, 1'b1, 2'b00, 16'h0, 16'h1234, 5, 1'b0));
      req_q.push_back(mk_req(23'h022222, 1'b1, 2'b11, 16'h0, 16'h4321, -1, 1'b1));
      drive_req();
      for (int g = 0; g < 300 && busy(); g++) begin
         cyc();
         rel = ncount - cur_f1;
         if (acc_log.size() == 1 && (rel == 2 || rel == 8)) begin
            vectors++;
            if ({BUS_AS_N, BUS_UDS_N, BUS_LDS_N} !== 3'b011) begin
               miscompares++;
               $display("FAIL as_only: rel %0d got %b, expected 011",
                        rel, {BUS_AS_N, BUS_UDS_N, BUS_LDS_N});
            end
         end
      end
      bound_check("back_to_back");
      vectors++;
      if (acc_log.size() != 2 || resp_log.size() == 0 ||
          (acc_log.size() == 2 && resp_log.size() > 0 && acc_log[1] != resp_log[0] + 1)) begin
         miscompares++;
         $display("FAIL b2b_accept: %0d accepts, %0d responses, expected 2nd accept on resp edge",
                  acc_log.size(), resp_log.size());
      end
   endtask

   initial begin
      RESET = 1'b1; MCCLK_FALLING = 1'b0; MCCLK_RISING = 1'b0; DTACK_LATCH = 1'b0;
      REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_RW = 1'b1; REQ_BE = '0; REQ_WDATA = '0;
      BUS_D_IN = '0;
      test_reset();
      test_word_read();
      test_byte_write();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      repeat (4) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
